// File: rtl/layer_sequencer_pkg.sv
// Shared definitions for the layer sequencer: widths, default region/drain
// parameters and the FSM state encoding.
package layer_sequencer_pkg;

  localparam int unsigned AddrW = 8;
  localparam int unsigned DataW = 8;

  localparam int unsigned RegionBDefault  = 128;
  localparam int unsigned DrainCycDefault = 2;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StArm,
    StRun,
    StDrain,
    StAdvance,
    StFinish
  } state_e;

endpackage

// File: rtl/layer_base_calc.sv
// Next weight-base computation: base + n_in * nk with a full-width product,
// flagging any result that no longer fits the 8-bit address space.
module layer_base_calc
  import layer_sequencer_pkg::*;
(
  input  logic [DataW-1:0] base,
  input  logic [DataW-1:0] n_in,
  input  logic [DataW-1:0] nk,
  output logic [DataW-1:0] next_base,
  output logic             overflow
);

  logic [2*DataW-1:0] product;
  logic [2*DataW:0]   sum;

  assign product   = 16'(n_in) * 16'(nk);
  assign sum       = {{(DataW + 1){1'b0}}, base} + {1'b0, product};
  assign next_base = sum[DataW-1:0];
  assign overflow  = |sum[2*DataW:DataW];

endmodule

// File: rtl/layer_sequencer.sv
// Walks a stored program of per-layer neuron counts, arming the address
// generator and MAC for each layer and ping-ponging the neuron RAM regions.
module layer_sequencer
  import layer_sequencer_pkg::*;
#(
  parameter int unsigned N_INPUTS  = 4,
  parameter int unsigned REGION_B  = RegionBDefault,
  parameter int unsigned DRAIN_CYC = DrainCycDefault
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [AddrW-1:0] instr_addr,
  input  logic [DataW-1:0] instr_data,
  output logic             ag_rst,
  output logic             ag_start,
  output logic [DataW-1:0] ag_nk,
  input  logic             ag_finished,
  output logic [AddrW-1:0] read_neuro_base,
  output logic [AddrW-1:0] write_neuro_base,
  output logic [AddrW-1:0] read_weight_base,
  output logic             alu_rst,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [DataW-1:0] layer_count
);

  localparam logic [AddrW-1:0] RegionBase = AddrW'(REGION_B);
  localparam logic [DataW-1:0] NInInit    = DataW'(N_INPUTS);
  localparam logic [DataW-1:0] DrainLast  = DataW'(DRAIN_CYC - 1);

  state_e           state_q, state_d;
  logic [AddrW-1:0] instr_addr_q, rd_neuro_q, wr_neuro_q, rd_weight_q;
  logic [DataW-1:0] ag_nk_q, n_in_q, layer_count_q, drain_cnt_q;
  logic             error_q, ag_start_q;
  logic [AddrW-1:0] next_weight;
  logic             weight_ovf, fetch_err, prog_end;

  layer_base_calc u_base_calc (
    .base      (rd_weight_q),
    .n_in      (n_in_q),
    .nk        (ag_nk_q),
    .next_base (next_weight),
    .overflow  (weight_ovf)
  );

  assign prog_end  = (instr_data == '0);
  assign fetch_err = (instr_data > RegionBase) || (n_in_q > RegionBase);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (start) state_d = StFetch;
      StFetch:   state_d = (prog_end || fetch_err) ? StFinish : StArm;
      StArm:     state_d = StRun;
      StRun:     if (ag_finished) state_d = StDrain;
      StDrain:   if (drain_cnt_q == DrainLast) state_d = StAdvance;
      // The last instruction slot ends the program rather than wrapping to 0.
      StAdvance: state_d = (weight_ovf || instr_addr_q == '1) ? StFinish : StFetch;
      StFinish:  state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    busy    = (state_q != StIdle);
    done    = (state_q == StFinish);
    ag_rst  = (state_q == StIdle) || (state_q == StArm);
    alu_rst = ag_rst;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_addr_q  <= '0;
      rd_neuro_q    <= '0;
      wr_neuro_q    <= '0;
      rd_weight_q   <= '0;
      ag_nk_q       <= '0;
      n_in_q        <= '0;
      layer_count_q <= '0;
      drain_cnt_q   <= '0;
      error_q       <= 1'b0;
      ag_start_q    <= 1'b0;
    end else begin
      // ARM always falls through to RUN, so this marks the first RUN cycle.
      ag_start_q <= (state_q == StArm);
      case (state_q)
        StIdle: begin
          if (start) begin
            instr_addr_q  <= '0;
            layer_count_q <= '0;
            error_q       <= 1'b0;
            rd_neuro_q    <= '0;
            wr_neuro_q    <= RegionBase;
            rd_weight_q   <= '0;
            n_in_q        <= NInInit;
          end
        end
        StFetch: begin
          if (!prog_end) begin
            if (fetch_err) error_q <= 1'b1;
            else           ag_nk_q <= instr_data;
          end
        end
        StRun:   drain_cnt_q <= '0;
        StDrain: drain_cnt_q <= drain_cnt_q + 1'b1;
        StAdvance: begin
          if (weight_ovf) begin
            error_q <= 1'b1;
          end else begin
            rd_weight_q   <= next_weight;
            rd_neuro_q    <= wr_neuro_q;
            wr_neuro_q    <= rd_neuro_q;
            n_in_q        <= ag_nk_q;
            layer_count_q <= layer_count_q + 1'b1;
            if (instr_addr_q != '1) instr_addr_q <= instr_addr_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign instr_addr       = instr_addr_q;
  assign ag_start         = ag_start_q;
  assign ag_nk            = ag_nk_q;
  assign read_neuro_base  = rd_neuro_q;
  assign write_neuro_base = wr_neuro_q;
  assign read_weight_base = rd_weight_q;
  assign error            = error_q;
  assign layer_count      = layer_count_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// Scoreboard bench for layer_sequencer: a program-level reference model queues
// expected per-layer bases and run results, a monitor checks them on ag_start/done.
module tb_layer_sequencer;

  localparam int unsigned NIn = 4;

  typedef struct {
    logic [7:0] rwb;
    logic [7:0] rnb;
    logic [7:0] wnb;
    logic [7:0] nk;
  } layer_t;

  typedef struct {
    logic [7:0] lc;
    logic       err;
  } run_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       ag_finished = 1'b0;
  logic [7:0] instr_addr, instr_data, ag_nk, rnb, wnb, rwb, layer_count;
  logic       ag_rst, ag_start, alu_rst, busy, done, error;

  logic [7:0] imem [256];
  layer_t     exp_layers[$];
  run_t       exp_runs[$];
  layer_t     el;
  run_t       er;
  int         n_vec = 0;
  int         n_err = 0;
  int         fixed_lat = -1;
  bit         noise_en = 1'b0;
  int         ag_cnt = -1;

  assign instr_data = imem[instr_addr];

  always #5 clk = ~clk;

  layer_sequencer #(
    .N_INPUTS  (NIn),
    .REGION_B  (128),
    .DRAIN_CYC (2)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .instr_addr       (instr_addr),
    .instr_data       (instr_data),
    .ag_rst           (ag_rst),
    .ag_start         (ag_start),
    .ag_nk            (ag_nk),
    .ag_finished      (ag_finished),
    .read_neuro_base  (rnb),
    .write_neuro_base (wnb),
    .read_weight_base (rwb),
    .alu_rst          (alu_rst),
    .busy             (busy),
    .done             (done),
    .error            (error),
    .layer_count      (layer_count)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: event seen, none expected", name);
  endtask

  // Program-level reference: walks imem applying the layer rules arithmetically.
  task automatic model_run();
    int  rw = 0, rn = 0, wn = 128, nin = NIn, lc = 0, d, s, t;
    bit  e = 1'b0;
    for (int a = 0; a < 256; a++) begin
      d = int'(imem[a]);
      if (d == 0) break;
      if (d > 128 || nin > 128) begin
        e = 1'b1;
        break;
      end
      exp_layers.push_back('{rwb: 8'(rw), rnb: 8'(rn), wnb: 8'(wn), nk: 8'(d)});
      s = rw + nin * d;
      if (s > 255) begin
        e = 1'b1;
        break;
      end
      rw = s;
      t = rn; rn = wn; wn = t;
      nin = d;
      lc++;
    end
    exp_runs.push_back('{lc: 8'(lc), err: e});
  endtask

  // Address-generator stand-in: answers each ag_start after a latency, and
  // optionally injects stray ag_finished pulses while the sequencer is idle.
  always @(negedge clk) begin
    ag_finished = 1'b0;
    if (!reset) begin
      ag_cnt = -1;
    end else if (ag_start) begin
      ag_cnt = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 6));
      if (ag_cnt == 0) begin
        ag_finished = 1'b1;
        ag_cnt = -1;
      end
    end else if (ag_cnt > 0) begin
      ag_cnt--;
      if (ag_cnt == 0) begin
        ag_finished = 1'b1;
        ag_cnt = -1;
      end
    end else if (noise_en && !busy && $urandom_range(0, 3) == 0) begin
      ag_finished = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      if (ag_start) begin
        if (exp_layers.size() == 0) unexpected("ag_start_unexpected");
        else begin
          el = exp_layers.pop_front();
          chk("layer_read_weight_base", 16'(rwb), 16'(el.rwb));
          chk("layer_read_neuro_base", 16'(rnb), 16'(el.rnb));
          chk("layer_write_neuro_base", 16'(wnb), 16'(el.wnb));
          chk("layer_ag_nk", 16'(ag_nk), 16'(el.nk));
        end
      end
      if (done) begin
        if (exp_runs.size() == 0) unexpected("done_unexpected");
        else begin
          er = exp_runs.pop_front();
          chk("run_layer_count", 16'(layer_count), 16'(er.lc));
          chk("run_error", 16'(error), 16'(er.err));
          chk("run_busy_at_done", 16'(busy), 16'd1);
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ag_rst"}, 16'(ag_rst), 16'd1);
    chk({tag, "_alu_rst"}, 16'(alu_rst), 16'd1);
    chk({tag, "_ag_start"}, 16'(ag_start), 16'd0);
    chk({tag, "_busy"}, 16'(busy), 16'd0);
    chk({tag, "_done"}, 16'(done), 16'd0);
    chk({tag, "_error"}, 16'(error), 16'd0);
    chk({tag, "_read_neuro_base"}, 16'(rnb), 16'd0);
    chk({tag, "_write_neuro_base"}, 16'(wnb), 16'd0);
    chk({tag, "_read_weight_base"}, 16'(rwb), 16'd0);
    chk({tag, "_instr_addr"}, 16'(instr_addr), 16'd0);
    chk({tag, "_ag_nk"}, 16'(ag_nk), 16'd0);
    chk({tag, "_layer_count"}, 16'(layer_count), 16'd0);
  endtask

  task automatic load_prog(input logic [7:0] p0, input logic [7:0] p1,
                           input logic [7:0] p2, input logic [7:0] p3);
    for (int i = 0; i < 256; i++) imem[i] = 8'($urandom_range(1, 255));
    imem[0] = p0; imem[1] = p1; imem[2] = p2; imem[3] = p3;
  endtask

  // Issues one start, waits for done; cyc counts negedges after the accepting edge's follower.
  task automatic run_prog(input int lat, input bit noise, output int cyc);
    fixed_lat = lat;
    noise_en  = noise;
    model_run();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 16'(busy), 16'd1);
    chk("error_cleared_on_start", 16'(error), 16'd0);
    chk("ag_rst_released_in_fetch", 16'(ag_rst), 16'd0);
    cyc = 0;
    while (!done && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (!done) start = noise && busy && ($urandom_range(0, 2) == 0);
    end
    start = 1'b0;
    chk("done_seen", 16'(done), 16'd1);
    @(negedge clk);
    chk("done_single_pulse", 16'(done), 16'd0);
    chk("idle_after_done", 16'(busy), 16'd0);
    chk("idle_ag_rst", 16'(ag_rst), 16'd1);
    noise_en = 1'b0;
  endtask

  initial begin
    int cyc, wait_cyc, len, r;
    for (int i = 0; i < 256; i++) imem[i] = 8'd0;
    #12;
    check_reset_outputs("por");
    @(negedge clk);
    reset = 1'b1;

    load_prog(8'd3, 8'd2, 8'd0, 8'd0);
    run_prog(5, 1'b0, cyc);

    load_prog(8'd0, 8'd1, 8'd1, 8'd0);
    run_prog(-1, 1'b0, cyc);
    chk("empty_prog_latency", 16'(cyc), 16'd1);

    load_prog(8'd200, 8'd0, 8'd0, 8'd0);
    run_prog(-1, 1'b0, cyc);
    chk("fetch_err_latency", 16'(cyc), 16'd1);

    load_prog(8'd64, 8'd16, 8'd0, 8'd0);
    run_prog(-1, 1'b0, cyc);

    load_prog(8'd128, 8'd1, 8'd0, 8'd0);
    run_prog(-1, 1'b0, cyc);

    load_prog(8'd3, 8'd2, 8'd0, 8'd0);
    run_prog(5, 1'b1, cyc);

    // Reset during the first layer's RUN, then rerun the same program.
    load_prog(8'd5, 8'd6, 8'd7, 8'd0);
    fixed_lat = 6;
    model_run();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_cyc = 0;
    while (!ag_start && wait_cyc < 50) begin
      @(negedge clk);
      wait_cyc++;
    end
    chk("ag_start_before_reset", 16'(ag_start), 16'd1);
    @(posedge clk);
    #2 reset = 1'b0;
    #1 check_reset_outputs("midrun");
    exp_layers.delete();
    exp_runs.delete();
    @(negedge clk);
    reset = 1'b1;
    run_prog(6, 1'b0, cyc);

    for (int k = 0; k < 30; k++) begin
      for (int i = 0; i < 256; i++) imem[i] = 8'($urandom_range(1, 255));
      len = $urandom_range(0, 5);
      for (int j = 0; j < len; j++) begin
        r = $urandom_range(0, 99);
        if (r < 70)      imem[j] = 8'($urandom_range(1, 16));
        else if (r < 85) imem[j] = 8'($urandom_range(17, 128));
        else if (r < 93) imem[j] = 8'($urandom_range(129, 255));
        else             imem[j] = 8'($urandom_range(40, 100));
      end
      imem[len] = 8'd0;
      run_prog(-1, 1'($urandom_range(0, 1)), cyc);
    end

    chk("layers_queue_drained", 16'(exp_layers.size()), 16'd0);
    chk("runs_queue_drained", 16'(exp_runs.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
